// File: rtl/tcycle_bus_scheduler.sv
// tcycle_bus_scheduler: T/M-cycle tick generator and phase-sliced shared memory bus arbiter with DMG access locking
module tcycle_bus_scheduler #(
    parameter int CLKS_PER_TCYCLE = 32
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        enable_in,
    input  logic [1:0]  ppu_mode_in,
    input  logic        cpu_req_in,
    input  logic [15:0] cpu_addr_in,
    input  logic        cpu_we_in,
    input  logic [7:0]  cpu_wdata_in,
    input  logic        ppu_req_in,
    input  logic [15:0] ppu_addr_in,
    input  logic        dma_req_in,
    input  logic [15:0] dma_addr_in,
    input  logic        dma_we_in,
    input  logic [7:0]  dma_wdata_in,
    output logic [15:0] mem_addr_out,
    output logic        mem_we_out,
    output logic [7:0]  mem_wdata_out,
    output logic        mem_valid_out,
    input  logic [7:0]  mem_rdata_in,
    input  logic        mem_rdata_valid_in,
    output logic        cpu_ack_out,
    output logic        ppu_ack_out,
    output logic        dma_ack_out,
    output logic [7:0]  rdata_out,
    output logic        timeout_out,
    output logic        tclk_out,
    output logic        mclk_out,
    output logic [1:0]  phase_out
);
    localparam int PL = CLKS_PER_TCYCLE / 4;
    localparam int CW = $clog2(CLKS_PER_TCYCLE);
    localparam int OW = $clog2(PL);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_LOCKED} state_t;

    state_t      r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]  r_tcount;
    logic [1:0]  r_phase;
    logic [15:0] r_addr;
    logic        r_we;
    logic [7:0]  r_wdata;
    logic        r_valid;
    logic        r_got;
    logic [7:0]  r_data;
    logic [2:0]  r_ack;
    logic [7:0]  r_rdata;
    logic        r_timeout;
    logic        r_tclk;
    logic        r_mclk;

    logic [1:0]    w_phase;
    logic [OW-1:0] w_off;
    logic          w_req;
    logic [15:0]   w_addr;
    logic          w_we;
    logic [7:0]    w_wdata;
    logic          w_vram;
    logic          w_oam;
    logic          w_hram;
    logic          w_lock;
    logic          w_cap;
    logic          w_have;

    assign w_phase = 2'(r_cnt / CW'(PL));
    assign w_off   = OW'(r_cnt % CW'(PL));
    assign w_vram  = cpu_addr_in[15:13] == 3'b100;
    assign w_oam   = cpu_addr_in >= 16'hFE00 && cpu_addr_in <= 16'hFE9F;
    assign w_hram  = cpu_addr_in >= 16'hFF80 && cpu_addr_in <= 16'hFFFE;
    // a read that sees data this edge counts as complete, so the ack edge can use it directly
    assign w_cap   = r_valid && !r_we && mem_rdata_valid_in;
    assign w_have  = r_got || w_cap;

    // route the current phase owner's request onto the shared sample path and evaluate CPU locking
    always_comb begin
        w_req   = w_phase == 2'd0 ? cpu_req_in   : w_phase == 2'd1 ? ppu_req_in  : w_phase == 2'd2 ? dma_req_in   : 1'b0;
        w_addr  = w_phase == 2'd0 ? cpu_addr_in  : w_phase == 2'd1 ? ppu_addr_in : dma_addr_in;
        w_we    = w_phase == 2'd0 ? cpu_we_in    : w_phase == 2'd2 ? dma_we_in   : 1'b0;
        w_wdata = w_phase == 2'd0 ? cpu_wdata_in : w_phase == 2'd2 ? dma_wdata_in : 8'h00;
        w_lock  = w_phase == 2'd0 && ((w_vram && ppu_mode_in == 2'd3) ||
                                      (w_oam && (ppu_mode_in[1] || dma_req_in)) ||
                                      (dma_req_in && !w_hram));
    end

    // tick counter plus the per-phase sample/bus/ack state machine; all outputs registered
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_tcount  <= 2'd0;
            r_phase   <= 2'd0;
            r_addr    <= 16'h0000;
            r_we      <= 1'b0;
            r_wdata   <= 8'h00;
            r_valid   <= 1'b0;
            r_got     <= 1'b0;
            r_data    <= 8'h00;
            r_ack     <= 3'b000;
            r_rdata   <= 8'h00;
            r_timeout <= 1'b0;
            r_tclk    <= 1'b0;
            r_mclk    <= 1'b0;
        end else begin
            r_tclk    <= 1'b0;
            r_mclk    <= 1'b0;
            r_ack     <= 3'b000;
            r_timeout <= 1'b0;
            r_valid   <= 1'b0;
            if (enable_in) begin
                r_cnt   <= r_cnt == CW'(CLKS_PER_TCYCLE - 1) ? '0 : r_cnt + 1'b1;
                r_phase <= w_phase;
                if (r_cnt == '0) begin
                    r_tclk   <= 1'b1;
                    r_mclk   <= r_tcount == 2'd0;
                    r_tcount <= r_tcount + 2'd1;
                end
                if (w_cap) begin
                    r_got  <= 1'b1;
                    r_data <= mem_rdata_in;
                end
                if (w_off == '0) begin
                    r_got   <= 1'b0;
                    r_state <= !w_req ? S_IDLE : w_lock ? S_LOCKED : S_BUS;
                    if (w_req && !w_lock) begin
                        r_addr  <= w_addr;
                        r_we    <= w_we;
                        r_wdata <= w_wdata;
                    end
                end else if (w_off == OW'(PL - 1)) begin
                    if (r_state != S_IDLE) begin
                        r_ack     <= 3'(4'b0001 << w_phase);
                        r_rdata   <= (r_state == S_BUS && !r_we && w_have) ? (r_got ? r_data : mem_rdata_in) : 8'hFF;
                        r_timeout <= r_state == S_BUS && !r_we && !w_have;
                    end
                    r_state <= S_IDLE;
                end else begin
                    r_valid <= r_state == S_BUS && !w_have;
                end
            end
        end
    end

    assign mem_addr_out  = r_addr;
    assign mem_we_out    = r_valid && r_we;
    assign mem_wdata_out = r_wdata;
    assign mem_valid_out = r_valid;
    assign cpu_ack_out   = r_ack[0];
    assign ppu_ack_out   = r_ack[1];
    assign dma_ack_out   = r_ack[2];
    assign rdata_out     = r_rdata;
    assign timeout_out   = r_timeout;
    assign tclk_out      = r_tclk;
    assign mclk_out      = r_mclk;
    assign phase_out     = r_phase;
endmodule

// File: tb/tb_tcycle_bus_scheduler.sv
// tb_tcycle_bus_scheduler: table-driven T-cycle vectors plus freeze and mid-access reset sequences
module tb_tcycle_bus_scheduler;
    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        enable_in;
    logic [1:0]  ppu_mode_in;
    logic        cpu_req_in;
    logic [15:0] cpu_addr_in;
    logic        cpu_we_in;
    logic [7:0]  cpu_wdata_in;
    logic        ppu_req_in;
    logic [15:0] ppu_addr_in;
    logic        dma_req_in;
    logic [15:0] dma_addr_in;
    logic        dma_we_in;
    logic [7:0]  dma_wdata_in;
    logic [15:0] mem_addr_out;
    logic        mem_we_out;
    logic [7:0]  mem_wdata_out;
    logic        mem_valid_out;
    logic [7:0]  mem_rdata_in;
    logic        mem_rdata_valid_in;
    logic        cpu_ack_out;
    logic        ppu_ack_out;
    logic        dma_ack_out;
    logic [7:0]  rdata_out;
    logic        timeout_out;
    logic        tclk_out;
    logic        mclk_out;
    logic [1:0]  phase_out;

    tcycle_bus_scheduler #(.CLKS_PER_TCYCLE(32)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .enable_in(enable_in), .ppu_mode_in(ppu_mode_in),
        .cpu_req_in(cpu_req_in), .cpu_addr_in(cpu_addr_in), .cpu_we_in(cpu_we_in), .cpu_wdata_in(cpu_wdata_in),
        .ppu_req_in(ppu_req_in), .ppu_addr_in(ppu_addr_in),
        .dma_req_in(dma_req_in), .dma_addr_in(dma_addr_in), .dma_we_in(dma_we_in), .dma_wdata_in(dma_wdata_in),
        .mem_addr_out(mem_addr_out), .mem_we_out(mem_we_out), .mem_wdata_out(mem_wdata_out),
        .mem_valid_out(mem_valid_out), .mem_rdata_in(mem_rdata_in), .mem_rdata_valid_in(mem_rdata_valid_in),
        .cpu_ack_out(cpu_ack_out), .ppu_ack_out(ppu_ack_out), .dma_ack_out(dma_ack_out),
        .rdata_out(rdata_out), .timeout_out(timeout_out), .tclk_out(tclk_out), .mclk_out(mclk_out),
        .phase_out(phase_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic             c_req;
        logic [15:0]      c_a;
        logic             c_we;
        logic [7:0]       c_wd;
        logic             p_req;
        logic [15:0]      p_a;
        logic             d_req;
        logic [15:0]      d_a;
        logic             d_we;
        logic [7:0]       d_wd;
        logic [1:0]       mode;
        int               rl;
        logic [7:0]       rv;
        logic [2:0][7:0]  e_rd;
        logic [2:0]       e_to;
        logic [2:0][2:0]  e_vc;
    } rec_t;

    int total = 0;
    int passed = 0;
    int tc = 0;
    rec_t v[13];
    logic [41:0] w_all;

    assign w_all = {mem_addr_out, mem_we_out, mem_wdata_out, mem_valid_out, cpu_ack_out, ppu_ack_out,
                    dma_ack_out, rdata_out, timeout_out, tclk_out, mclk_out, phase_out};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    function automatic rec_t mk(input logic c_req, input logic [15:0] c_a, input logic c_we, input logic [7:0] c_wd,
                                input logic p_req, input logic [15:0] p_a,
                                input logic d_req, input logic [15:0] d_a, input logic d_we, input logic [7:0] d_wd,
                                input logic [1:0] mode, input int rl, input logic [7:0] rv,
                                input logic [23:0] e_rd, input logic [2:0] e_to, input logic [8:0] e_vc);
        rec_t r;
        r.c_req = c_req; r.c_a = c_a; r.c_we = c_we; r.c_wd = c_wd;
        r.p_req = p_req; r.p_a = p_a;
        r.d_req = d_req; r.d_a = d_a; r.d_we = d_we; r.d_wd = d_wd;
        r.mode = mode; r.rl = rl; r.rv = rv;
        r.e_rd = e_rd; r.e_to = e_to; r.e_vc = e_vc;
        return r;
    endfunction

    // entered at label 31 of a T-cycle; applies the record and observes labels 0..31 of the next one
    task automatic run_rec(input int n, input rec_t r);
        int vc[3];
        logic got[3];
        logic [7:0] rd[3];
        logic to[3];
        logic [15:0] fa[3];
        logic fw[3];
        logic [7:0] fd[3];
        logic [2:0] acks;
        logic e_ack;
        logic [15:0] e_a;
        logic e_we;
        logic [7:0] e_wd;
        int tbad;
        int stray;
        int p;
        string nm[3];
        nm = '{"cpu", "ppu", "dma"};
        tbad = 0;
        stray = 0;
        for (int i = 0; i < 3; i++) begin
            vc[i] = 0; got[i] = 1'b0; rd[i] = 8'h00; to[i] = 1'b0; fa[i] = 16'h0; fw[i] = 1'b0; fd[i] = 8'h0;
        end
        cpu_req_in = r.c_req; cpu_addr_in = r.c_a; cpu_we_in = r.c_we; cpu_wdata_in = r.c_wd;
        ppu_req_in = r.p_req; ppu_addr_in = r.p_a;
        dma_req_in = r.d_req; dma_addr_in = r.d_a; dma_we_in = r.d_we; dma_wdata_in = r.d_wd;
        ppu_mode_in = r.mode;
        for (int l = 0; l < 32; l++) begin
            @(negedge clk_in);
            p = l / 8;
            if (tclk_out !== (l == 0) || mclk_out !== (l == 0 && tc % 4 == 0) || phase_out !== 2'(p)) tbad++;
            if (l == 0) tc++;
            if (mem_valid_out) begin
                if (p < 3) begin
                    if (vc[p] == 0) begin
                        fa[p] = mem_addr_out; fw[p] = mem_we_out; fd[p] = mem_wdata_out;
                    end
                    vc[p]++;
                end else stray++;
            end
            if (mem_we_out && !mem_valid_out) stray++;
            acks = {dma_ack_out, ppu_ack_out, cpu_ack_out};
            for (int i = 0; i < 3; i++) begin
                if (acks[i]) begin
                    if (l == 8 * i + 7) begin
                        got[i] = 1'b1; rd[i] = rdata_out; to[i] = timeout_out;
                    end else stray++;
                end
            end
            if (timeout_out && acks == 3'b000) stray++;
            mem_rdata_valid_in = (l == r.rl);
            mem_rdata_in = (l == r.rl) ? r.rv : 8'h00;
        end
        chk($sformatf("v%0d tick/phase", n), 64'(tbad), 64'd0);
        chk($sformatf("v%0d stray", n), 64'(stray), 64'd0);
        for (int i = 0; i < 3; i++) begin
            e_ack = i == 0 ? r.c_req : i == 1 ? r.p_req : r.d_req;
            e_a   = i == 0 ? r.c_a : i == 1 ? r.p_a : r.d_a;
            e_we  = i == 0 ? r.c_we : i == 2 ? r.d_we : 1'b0;
            e_wd  = i == 0 ? r.c_wd : r.d_wd;
            chk($sformatf("v%0d %s ack", n, nm[i]), 64'(got[i]), 64'(e_ack));
            chk($sformatf("v%0d %s valid cycles", n, nm[i]), 64'(vc[i]), 64'(r.e_vc[i]));
            if (e_ack) begin
                chk($sformatf("v%0d %s rdata", n, nm[i]), 64'(rd[i]), 64'(r.e_rd[i]));
                chk($sformatf("v%0d %s timeout", n, nm[i]), 64'(to[i]), 64'(r.e_to[i]));
            end
            if (r.e_vc[i] != 3'd0) begin
                chk($sformatf("v%0d %s addr/we", n, nm[i]), {47'd0, fa[i], fw[i]}, {47'd0, e_a, e_we});
                if (e_we) chk($sformatf("v%0d %s wdata", n, nm[i]), 64'(fd[i]), 64'(e_wd));
            end
        end
    endtask

    initial begin
        int bad;
        int cnt;
        v[0]  = mk(0, 16'h0000, 0, 8'h00, 0, 16'h0000, 0, 16'h0000, 0, 8'h00, 2'd0, -1, 8'h00, 24'hFFFFFF, 3'b000, {3'd0, 3'd0, 3'd0});
        v[1]  = mk(1, 16'hC000, 0, 8'h00, 0, 16'h0000, 0, 16'h0000, 0, 8'h00, 2'd0,  3, 8'h5A, 24'hFFFF5A, 3'b000, {3'd0, 3'd0, 3'd3});
        v[2]  = mk(1, 16'h8010, 0, 8'h00, 0, 16'h0000, 0, 16'h0000, 0, 8'h00, 2'd3, -1, 8'h00, 24'hFFFFFF, 3'b000, {3'd0, 3'd0, 3'd0});
        v[3]  = mk(1, 16'hFE00, 1, 8'h11, 0, 16'h0000, 1, 16'hFE05, 1, 8'h22, 2'd0, -1, 8'h00, 24'hFFFFFF, 3'b000, {3'd6, 3'd0, 3'd0});
        v[4]  = mk(1, 16'hFF90, 0, 8'h00, 0, 16'h0000, 1, 16'hFE01, 1, 8'h33, 2'd0,  2, 8'h3C, 24'hFFFF3C, 3'b000, {3'd6, 3'd0, 3'd2});
        v[5]  = mk(0, 16'h0000, 0, 8'h00, 1, 16'h9800, 0, 16'h0000, 0, 8'h00, 2'd3, -1, 8'h00, 24'hFFFFFF, 3'b010, {3'd0, 3'd6, 3'd0});
        v[6]  = mk(1, 16'hC000, 1, 8'hAB, 0, 16'h0000, 0, 16'h0000, 0, 8'h00, 2'd3, -1, 8'h00, 24'hFFFFFF, 3'b000, {3'd0, 3'd0, 3'd6});
        v[7]  = mk(1, 16'hFE50, 0, 8'h00, 1, 16'hFE10, 0, 16'h0000, 0, 8'h00, 2'd2, 12, 8'hA5, 24'hFFA5FF, 3'b000, {3'd0, 3'd4, 3'd0});
        v[8]  = mk(1, 16'h9000, 0, 8'h00, 0, 16'h0000, 0, 16'h0000, 0, 8'h00, 2'd2,  6, 8'h42, 24'hFFFF42, 3'b000, {3'd0, 3'd0, 3'd6});
        v[9]  = mk(1, 16'hFFFF, 0, 8'h00, 0, 16'h0000, 1, 16'hC100, 0, 8'h00, 2'd0, -1, 8'h00, 24'hFFFFFF, 3'b100, {3'd6, 3'd0, 3'd0});
        v[10] = mk(1, 16'hC000, 0, 8'h00, 0, 16'h0000, 0, 16'h0000, 0, 8'h00, 2'd0, 27, 8'h99, 24'hFFFFFF, 3'b001, {3'd0, 3'd0, 3'd6});
        v[11] = mk(1, 16'hD000, 0, 8'h00, 1, 16'h8000, 1, 16'hFE9F, 1, 8'h44, 2'd0,  7, 8'h55, 24'hFFFFFF, 3'b010, {3'd6, 3'd6, 3'd0});
        v[12] = mk(0, 16'h0000, 0, 8'h00, 1, 16'h8800, 0, 16'h0000, 0, 8'h00, 2'd0, 14, 8'hE7, 24'hFFE7FF, 3'b000, {3'd0, 3'd6, 3'd0});

        rst_n_in = 1'b0; enable_in = 1'b1; ppu_mode_in = 2'd0;
        cpu_req_in = 1'b0; cpu_addr_in = 16'h0; cpu_we_in = 1'b0; cpu_wdata_in = 8'h0;
        ppu_req_in = 1'b0; ppu_addr_in = 16'h0;
        dma_req_in = 1'b0; dma_addr_in = 16'h0; dma_we_in = 1'b0; dma_wdata_in = 8'h0;
        mem_rdata_in = 8'h0; mem_rdata_valid_in = 1'b0;
        repeat (2) @(negedge clk_in);
        chk("reset outputs", 64'(w_all), 64'd0);
        rst_n_in = 1'b1;
        @(negedge clk_in);
        chk("first tclk/mclk/phase", {60'd0, tclk_out, mclk_out, phase_out}, {60'd0, 1'b1, 1'b1, 2'd0});
        tc = 1;
        repeat (31) @(negedge clk_in);

        for (int i = 0; i < 13; i++) run_rec(i, v[i]);

        // freeze mid-access at CPU off 3, then resume from the held offset
        cpu_req_in = 1'b1; cpu_addr_in = 16'hC000; cpu_we_in = 1'b0;
        ppu_req_in = 1'b0; dma_req_in = 1'b0; ppu_mode_in = 2'd0; mem_rdata_valid_in = 1'b0;
        repeat (4) @(negedge clk_in);
        tc++;
        chk("freeze valid before", 64'(mem_valid_out), 64'd1);
        enable_in = 1'b0;
        bad = 0;
        repeat (5) begin
            @(negedge clk_in);
            if (mem_valid_out || cpu_ack_out || tclk_out || mclk_out || phase_out !== 2'd0) bad++;
        end
        chk("freeze hold", 64'(bad), 64'd0);
        enable_in = 1'b1;
        cnt = 0;
        repeat (3) begin
            @(negedge clk_in);
            if (mem_valid_out) cnt++;
        end
        chk("freeze resume valid", 64'(cnt), 64'd3);
        @(negedge clk_in);
        chk("freeze ack", {54'd0, cpu_ack_out, timeout_out, rdata_out}, {54'd0, 1'b1, 1'b1, 8'hFF});
        cpu_req_in = 1'b0;
        repeat (24) @(negedge clk_in);

        // async reset at CPU off 4 with a read in flight
        cpu_req_in = 1'b1; cpu_addr_in = 16'hC000;
        repeat (5) @(negedge clk_in);
        chk("reset pre valid", 64'(mem_valid_out), 64'd1);
        rst_n_in = 1'b0;
        #1;
        chk("reset immediate", 64'(w_all), 64'd0);
        cpu_req_in = 1'b0;
        @(negedge clk_in);
        chk("reset held", 64'(w_all), 64'd0);
        rst_n_in = 1'b1;
        @(negedge clk_in);
        chk("post reset tclk", {60'd0, tclk_out, mclk_out, phase_out}, {60'd0, 1'b1, 1'b1, 2'd0});
        bad = 0;
        repeat (15) begin
            @(negedge clk_in);
            if (cpu_ack_out || ppu_ack_out || dma_ack_out || mem_valid_out || timeout_out) bad++;
        end
        chk("no stale ack", 64'(bad), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
